reg_op_ctrl: RTL

Sequencer and arbiter in front of the 4-entry, 9-bit register file (entries 1..4; address 0 means "no access").
- Runs two-operand register operations: read A, read B, compute, write back to dst.
- Shares the file's write port with a host (keypad-entry) writer.
- Owns reg_num, reg_sel and op1 exclusively.
- Absorbs the file's one-cycle registered read latency.

---
 rtl/reg_op_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/reg_op_ctrl.sv
// Sequencer/arbiter in front of a 4-entry register file: runs two-operand
// register operations (read A, read B, compute, write back) and shares the write port with a host writer.
module reg_op_ctrl #(
   parameter int W  = 9,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic [AW-1:0] src_a,
   input  logic [AW-1:0] src_b,
   input  logic [AW-1:0] dst,
   input  logic          wr_req,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   output logic          wr_ack,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [W-1:0]  result,
   output logic [AW-1:0] reg_num,
   output logic [AW-1:0] reg_sel,
   output logic [W-1:0]  op1,
   input  logic [W-1:0]  reg_val
);

   typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP_B, WB} state_t;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MOV, OP_AND} op_t;

   state_t        state, next_state;
   op_t           op_l;
   logic [AW-1:0] src_a_l, src_b_l, dst_l;
   logic [W-1:0]  a_l, b_l, alu;
   logic          accept, err_d;

   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (a != '0) && (a <= AW'(4));
   endfunction

   always_comb begin
      alu = a_l;
      case (op_l)
         OP_ADD:  alu = a_l + b_l;
         OP_SUB:  alu = a_l - b_l;
         OP_MOV:  alu = a_l;
         OP_AND:  alu = a_l & b_l;
         default: alu = a_l;
      endcase
   end

   // NOTE: every output gets a default before the case so no path can infer a latch.
   always_comb begin
      next_state = state;
      wr_ack     = 1'b0;
      reg_num    = '0;
      reg_sel    = '0;
      op1        = '0;
      err_d      = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            // Host has priority; start is only considered when no write is pending.
            if (wr_req) begin
               wr_ack = 1'b1;
               if (addr_ok(wr_addr)) begin
                  reg_num = wr_addr;
                  op1     = wr_data;
               end else begin
                  err_d = 1'b1;
               end
            end else if (start) begin
               if (addr_ok(src_a) && addr_ok(src_b) && addr_ok(dst)) begin
                  accept     = 1'b1;
                  next_state = RD_A;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RD_A: begin
            reg_sel    = src_a_l;
            next_state = RD_B;
         end
         RD_B: begin
            reg_sel    = src_b_l;
            next_state = CAP_B;
         end
         CAP_B: next_state = WB;
         WB: begin
            reg_num    = dst_l;
            op1        = alu;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == WB);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state   <= IDLE;
         op_l    <= OP_ADD;
         src_a_l <= '0;
         src_b_l <= '0;
         dst_l   <= '0;
         a_l     <= '0;
         b_l     <= '0;
         result  <= '0;
         err     <= 1'b0;
      end else begin
         state <= next_state;
         err   <= err_d;
         if (accept) begin
            op_l    <= op_t'(op);
            src_a_l <= src_a;
            src_b_l <= src_b;
            dst_l   <= dst;
         end
         // The file's read data trails reg_sel by one cycle.
         if (state == RD_B)  a_l    <= reg_val;
         if (state == CAP_B) b_l    <= reg_val;
         if (state == WB)    result <= alu;
      end
   end

endmodule
